io_hub: RTL and testbench
=========================

Name: io_hub

Overview:
- Responder side of the core's IO port. It consumes the core's out_en/addr_out/data_out write strobes and services its req_in/addr_in read strobes.
- Each core-visible IO address maps to a buffered external channel with a valid/ready handshake.
- The block sits between the core and the peripherals/testbench. The core never stalls, so the hub absorbs rate mismatch in per-channel FIFOs and flags any loss.

Parameters:
- NUBITS, 32, data width (matches core NUBITS).
- NUIOIN, 8, number of input channels (core read addresses).
- NUIOOU, 8, number of output channels (core write addresses).
- FDEPTH, 4, entries per channel FIFO; power of two, >= 2.
- Derived constants: IAW = max(1, $clog2(NUIOIN)), OAW = max(1, $clog2(NUIOOU)), PW = $clog2(FDEPTH).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_in  in  1  core read strobe
- addr_in  in  IAW  core read channel
- io_in  out  NUBITS  read data to core
- out_en  in  1  core write strobe
- addr_out  in  OAW  core write channel
- data_out  in  NUBITS  write data from core
- ext_in_data  in  NUIOIN*NUBITS  producer data, channel k at bits [k*NUBITS +: NUBITS]
- ext_in_valid  in  NUIOIN  producer valid per channel
- ext_in_ready  out  NUIOIN  hub ready per input channel
- ext_out_data  out  NUIOOU*NUBITS  consumer data, same packing
- ext_out_valid  out  NUIOOU  hub valid per output channel
- ext_out_ready  in  NUIOOU  consumer ready per channel
- ovf  out  NUIOOU  sticky output-FIFO overflow per channel
- udf  out  NUIOIN  sticky input-FIFO underflow per channel
- clr_err  in  1  synchronous clear of ovf/udf

Behaviour:
- Reset:
  - All FIFOs empty; io_in = 0; ovf = udf = 0; ext_out_valid = 0.
  - ext_in_ready = ~full & ~rst, so it is 0 while rst is high and 1 afterwards.
- Core write:
  - On a rising edge with out_en=1 and addr_out < NUIOOU, data_out is pushed into out-FIFO[addr_out].
  - If that FIFO is full and not popping that cycle, the word is dropped and ovf[addr_out] is set.
  - addr_out >= NUIOOU: write is ignored; no flag is set.
- Core read:
  - On a rising edge with req_in=1 and addr_in < NUIOIN, io_in is loaded with the head of in-FIFO[addr_in], which is then popped. Latency is 1: data is visible the cycle after req_in.
  - If that FIFO is empty: io_in is loaded with 0, there is no pop, and udf[addr_in] is set.
  - addr_in >= NUIOIN: io_in is loaded with 0; no flag is set.
  - io_in holds its value between reads.
- External input side:
  - A transfer occurs when ext_in_valid[k] & ext_in_ready[k] at a rising edge; the word is pushed into in-FIFO[k].
  - ext_in_ready[k] = ~full[k] & ~rst. It is combinational from FIFO state only, never from valid.
- External output side:
  - ext_out_valid[k] = ~empty[k]; ext_out_data slice k = head of out-FIFO[k].
  - Pop occurs on valid & ready.
  - Data is stable while valid=1 and ready=0.
- Simultaneous push and pop on one FIFO:
  - Full FIFO: pop occurs and push is accepted; count is unchanged, no ovf.
  - Empty FIFO: no bypass. The pop sees empty (udf for an input FIFO, no valid for an output FIFO), the push is stored, and count becomes 1.
- Error flags:
  - clr_err=1 clears all flags at the edge.
  - If a new error occurs in the same cycle, that bit ends set (set wins).
- Pointers and counters:
  - Read/write pointers are PW bits and wrap modulo FDEPTH.
  - Count is PW+1 bits; full when count == FDEPTH.
- Reset mid-operation: all contents are discarded immediately (asynchronous); an in-flight external handshake is lost.
- Single-channel configurations: when NUIOIN==1 (or NUIOOU==1), the corresponding addr_in (or addr_out) is ignored and channel 0 is used.

Decomposition:
- No shared package needed. Derived widths are localparams, computed the same way the core computes its IO address widths.
- One sub-module, io_fifo:
  - Parameters NBITS, DEPTH.
  - Ports clk, rst, push, din, pop, dout, full, empty.
  - Asynchronous reset; show-ahead dout.
  - Instantiated NUIOIN + NUIOOU times via generate.
- The io_hub top contains:
  - address decode and range checks;
  - the io_in register;
  - the sticky flag registers;
  - output-data packing.

Test Plan:
- Write path: reset, then out_en with addr_out=3, data_out=0xDEADBEEF, with ext_out_ready[3]=0. Expect ext_out_valid[3]=1 with data 0xDEADBEEF on the next cycle. Raise ready for one cycle: valid drops to 0; no other channel's valid toggles.
- Read path: push 0x11, 0x22 on ext_in channel 5. Issue req_in with addr_in=5 on two consecutive cycles. Expect io_in = 0x11, then 0x22, each one cycle after its req_in; ext_in_ready[5] stays 1.
- Overflow: FDEPTH=4, ext_out_ready[0]=0. Issue 5 writes to channel 0 (values 1..5). Expect ovf[0]=1 after the 5th write. Draining yields 1, 2, 3, 4 only. clr_err then clears ovf[0].
- Underflow and set-wins: req_in on an empty channel 2 gives io_in=0 and udf[2]=1. In a later cycle, assert clr_err together with another empty read of channel 2: udf[2] remains 1.
- Boundary concurrency:
  - Full FIFO: simultaneous core push and external pop leaves count at 4 with no ovf, and the FIFO order is preserved.
  - Empty input FIFO: simultaneous ext push and req_in sets udf and leaves 1 entry.
- Reset mid-stream: with 3 entries queued in in-FIFO[1], assert rst asynchronously between edges. Expect io_in=0, all valids 0, and ext_in_ready=0 immediately. After release, a read of channel 1 underflows.

Source files
------------

// File: rtl/io_fifo.sv
// Per-channel show-ahead FIFO. The head word is always visible on dout, and
// a full FIFO accepts a push when it is popped in the same cycle.
module io_fifo #(
  parameter int NBITS = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [NBITS-1:0] din,
  input  logic             pop,
  output logic [NBITS-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);

  logic [NBITS-1:0] mem [DEPTH];
  logic [PW-1:0]    wp, rp;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // Pop is checked first: an empty FIFO never bypasses a same-cycle push.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/io_hub.sv
// Responder side of the core IO port: buffers core writes toward external
// consumers and external producer data toward core reads.
module io_hub #(
  parameter int NUBITS = 32,
  parameter int NUIOIN = 8,
  parameter int NUIOOU = 8,
  parameter int FDEPTH = 4,
  localparam int IAW = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int OAW = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic [IAW-1:0]           addr_in,
  output logic [NUBITS-1:0]        io_in,
  input  logic                     out_en,
  input  logic [OAW-1:0]           addr_out,
  input  logic [NUBITS-1:0]        data_out,
  input  logic [NUIOIN*NUBITS-1:0] ext_in_data,
  input  logic [NUIOIN-1:0]        ext_in_valid,
  output logic [NUIOIN-1:0]        ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0] ext_out_data,
  output logic [NUIOOU-1:0]        ext_out_valid,
  input  logic [NUIOOU-1:0]        ext_out_ready,
  output logic [NUIOOU-1:0]        ovf,
  output logic [NUIOIN-1:0]        udf,
  input  logic                     clr_err
);
  localparam logic [IAW:0] NIN = (IAW+1)'(NUIOIN);
  localparam logic [OAW:0] NOU = (OAW+1)'(NUIOOU);

  // Single-channel builds ignore the address and always use channel 0.
  logic           rd_ok, wr_ok;
  logic [IAW-1:0] rd_sel;
  logic [OAW-1:0] wr_sel;
  assign rd_ok  = (NUIOIN == 1) || ({1'b0, addr_in}  < NIN);
  assign wr_ok  = (NUIOOU == 1) || ({1'b0, addr_out} < NOU);
  assign rd_sel = (NUIOIN == 1) ? '0 : addr_in;
  assign wr_sel = (NUIOOU == 1) ? '0 : addr_out;

  logic [NUIOIN-1:0][NUBITS-1:0] in_dout;
  logic [NUIOIN-1:0]             in_full, in_empty, rd_hit, udf_set;
  logic [NUIOOU-1:0]             out_full, out_empty, wr_hit, ovf_set, out_pop;

  assign ext_in_ready  = ~in_full & {NUIOIN{~rst}};
  assign ext_out_valid = ~out_empty;
  assign out_pop       = ext_out_ready & ~out_empty;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    assign rd_hit[k]  = req_in & rd_ok & (rd_sel == IAW'(k));
    assign udf_set[k] = rd_hit[k] & in_empty[k];
    io_fifo #(.NBITS(NUBITS), .DEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(ext_in_valid[k] & ext_in_ready[k]),
      .din(ext_in_data[k*NUBITS +: NUBITS]),
      .pop(rd_hit[k]),
      .dout(in_dout[k]), .full(in_full[k]), .empty(in_empty[k])
    );
  end

  for (genvar k = 0; k < NUIOOU; k++) begin : g_out
    assign wr_hit[k]  = out_en & wr_ok & (wr_sel == OAW'(k));
    // Full implies non-empty, so ready alone means a same-cycle pop frees a slot.
    assign ovf_set[k] = wr_hit[k] & out_full[k] & ~ext_out_ready[k];
    io_fifo #(.NBITS(NUBITS), .DEPTH(FDEPTH)) u_fifo (
      .clk(clk), .rst(rst),
      .push(wr_hit[k]), .din(data_out),
      .pop(out_pop[k]),
      .dout(ext_out_data[k*NUBITS +: NUBITS]),
      .full(out_full[k]), .empty(out_empty[k])
    );
  end

  logic [NUBITS-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUIOIN; k++)
      if (rd_hit[k] & ~in_empty[k]) rd_data = in_dout[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io_in <= '0;
      ovf   <= '0;
      udf   <= '0;
    end else begin
      if (req_in) io_in <= rd_data;
      ovf <= (clr_err ? '0 : ovf) | ovf_set;
      udf <= (clr_err ? '0 : udf) | udf_set;
    end
  end
endmodule

// File: tb/tb_io_hub.sv
// Self-checking bench for io_hub: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_io_hub;
  localparam int NB = 32, NI = 8, NO = 8, FD = 4, IAW = 3, OAW = 3;

  logic clk = 1'b0, rst;
  logic req_in, out_en, clr_err;
  logic [IAW-1:0] addr_in;
  logic [OAW-1:0] addr_out;
  logic [NB-1:0] io_in, data_out;
  logic [NI*NB-1:0] ext_in_data;
  logic [NI-1:0] ext_in_valid, ext_in_ready, udf;
  logic [NO*NB-1:0] ext_out_data;
  logic [NO-1:0] ext_out_valid, ext_out_ready, ovf;

  io_hub #(.NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .FDEPTH(FD)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .ovf(ovf), .udf(udf), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per channel, flags and the read register.
  int unsigned in_q[NI][$];
  int unsigned out_q[NO][$];
  logic [NI-1:0] udf_m;
  logic [NO-1:0] ovf_m;
  logic [NB-1:0] io_m;
  int chk = 0, err = 0;

  task automatic idle();
    req_in = 0; addr_in = '0; out_en = 0; addr_out = '0; data_out = '0;
    ext_in_data = '0; ext_in_valid = '0; ext_out_ready = '0; clr_err = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) in_q[k].delete();
    for (int k = 0; k < NO; k++) out_q[k].delete();
    udf_m = '0; ovf_m = '0; io_m = '0;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic tick();
    int sz_i[NI];
    int sz_o[NO];
    logic [NI-1:0] udf_new = '0;
    logic [NO-1:0] ovf_new = '0;
    for (int k = 0; k < NI; k++) sz_i[k] = in_q[k].size();
    for (int k = 0; k < NO; k++) sz_o[k] = out_q[k].size();
    if (req_in) begin
      if (int'(addr_in) < NI && sz_i[addr_in] > 0) io_m = in_q[addr_in].pop_front();
      else begin
        io_m = '0;
        if (int'(addr_in) < NI) udf_new[addr_in] = 1'b1;
      end
    end
    for (int k = 0; k < NI; k++)
      if (ext_in_valid[k] && sz_i[k] < FD) in_q[k].push_back(ext_in_data[k*NB +: NB]);
    for (int k = 0; k < NO; k++)
      if (ext_out_ready[k] && sz_o[k] > 0) void'(out_q[k].pop_front());
    if (out_en && int'(addr_out) < NO) begin
      if (sz_o[addr_out] < FD || (ext_out_ready[addr_out] && sz_o[addr_out] > 0))
        out_q[addr_out].push_back(data_out);
      else ovf_new[addr_out] = 1'b1;
    end
    if (clr_err) begin udf_m = '0; ovf_m = '0; end
    udf_m |= udf_new;
    ovf_m |= ovf_new;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); model_reset();
    rst = 1;
    #2;
    chk++; if (io_in !== '0) begin err++; $display("FAIL reset_io_in got %h want 0", io_in); end
    chk++; if (ext_out_valid !== '0) begin err++; $display("FAIL reset_valid got %b want 0", ext_out_valid); end
    chk++; if (ovf !== '0 || udf !== '0) begin err++; $display("FAIL reset_flags got ovf %b udf %b want 0", ovf, udf); end
    chk++; if (ext_in_ready !== '0) begin err++; $display("FAIL reset_ready got %b want 0", ext_in_ready); end
    @(posedge clk); #1; rst = 0; #1;
    chk++; if (ext_in_ready !== '1) begin err++; $display("FAIL post_reset_ready got %b want ff", ext_in_ready); end
  endtask

  task automatic test_write();
    idle(); out_en = 1; addr_out = 3; data_out = 32'hDEADBEEF;
    tick(); idle();
    chk++; if (ext_out_valid !== 8'b0000_1000) begin err++; $display("FAIL write_valid got %b want 00001000", ext_out_valid); end
    chk++; if (ext_out_data[3*NB +: NB] !== 32'hDEADBEEF) begin err++; $display("FAIL write_data got %h want deadbeef", ext_out_data[3*NB +: NB]); end
    ext_out_ready[3] = 1; tick(); idle();
    chk++; if (ext_out_valid !== '0) begin err++; $display("FAIL write_drain got %b want 0", ext_out_valid); end
  endtask

  task automatic test_read();
    idle(); ext_in_valid[5] = 1; ext_in_data[5*NB +: NB] = 32'h11; tick();
    ext_in_data[5*NB +: NB] = 32'h22; tick(); idle();
    chk++; if (ext_in_ready[5] !== 1'b1) begin err++; $display("FAIL read_ready got %b want 1", ext_in_ready[5]); end
    req_in = 1; addr_in = 5; tick();
    chk++; if (io_in !== 32'h11) begin err++; $display("FAIL read_first got %h want 11", io_in); end
    tick(); idle();
    chk++; if (io_in !== 32'h22) begin err++; $display("FAIL read_second got %h want 22", io_in); end
    tick();
    chk++; if (io_in !== 32'h22 || udf !== '0) begin err++; $display("FAIL read_hold got %h udf %b want 22 udf 0", io_in, udf); end
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 1; i <= 5; i++) begin
      out_en = 1; addr_out = 0; data_out = NB'(i); tick();
      if (i == 4) begin
        chk++; if (ovf[0] !== 1'b0) begin err++; $display("FAIL ovf_early got %b want 0", ovf[0]); end
      end
    end
    idle();
    chk++; if (ovf !== 8'b1) begin err++; $display("FAIL ovf_set got %b want 00000001", ovf); end
    ext_out_ready[0] = 1;
    for (int i = 1; i <= 4; i++) begin
      chk++;
      if (ext_out_valid[0] !== 1'b1 || ext_out_data[NB-1:0] !== NB'(i)) begin
        err++; $display("FAIL ovf_drain%0d got v%b %h want v1 %h", i, ext_out_valid[0], ext_out_data[NB-1:0], i);
      end
      tick();
    end
    chk++; if (ext_out_valid[0] !== 1'b0) begin err++; $display("FAIL ovf_empty got %b want 0", ext_out_valid[0]); end
    idle(); clr_err = 1; tick(); idle();
    chk++; if (ovf !== '0) begin err++; $display("FAIL ovf_clear got %b want 0", ovf); end
  endtask

  task automatic test_underflow();
    idle(); req_in = 1; addr_in = 2; tick(); idle();
    chk++; if (io_in !== '0 || udf !== 8'b0000_0100) begin err++; $display("FAIL udf_set got %h %b want 0 00000100", io_in, udf); end
    tick();
    clr_err = 1; req_in = 1; addr_in = 2; tick(); idle();
    chk++; if (udf[2] !== 1'b1) begin err++; $display("FAIL udf_set_wins got %b want 1", udf[2]); end
    clr_err = 1; tick(); idle();
    chk++; if (udf !== '0) begin err++; $display("FAIL udf_clear got %b want 0", udf); end
  endtask

  task automatic test_concurrency();
    idle();
    for (int i = 0; i < 4; i++) begin out_en = 1; addr_out = 6; data_out = NB'(10 + i); tick(); end
    out_en = 1; addr_out = 6; data_out = NB'(14); ext_out_ready[6] = 1; tick(); idle();
    chk++; if (ovf !== '0 || ext_out_valid[6] !== 1'b1) begin err++; $display("FAIL full_pushpop got ovf %b v %b want 0 1", ovf, ext_out_valid[6]); end
    ext_out_ready[6] = 1;
    for (int i = 11; i <= 14; i++) begin
      chk++;
      if (ext_out_valid[6] !== 1'b1 || ext_out_data[6*NB +: NB] !== NB'(i)) begin
        err++; $display("FAIL full_order got v%b %h want v1 %h", ext_out_valid[6], ext_out_data[6*NB +: NB], i);
      end
      tick();
    end
    idle();
    chk++; if (ext_out_valid[6] !== 1'b0) begin err++; $display("FAIL full_count got %b want 0", ext_out_valid[6]); end
    ext_in_valid[4] = 1; ext_in_data[4*NB +: NB] = 32'h44; req_in = 1; addr_in = 4; tick(); idle();
    chk++; if (udf[4] !== 1'b1 || io_in !== '0) begin err++; $display("FAIL empty_pushpop got udf %b io %h want 1 0", udf[4], io_in); end
    req_in = 1; addr_in = 4; tick();
    chk++; if (io_in !== 32'h44) begin err++; $display("FAIL empty_stored got %h want 44", io_in); end
    tick(); idle();
    chk++; if (io_in !== '0) begin err++; $display("FAIL empty_one_entry got %h want 0", io_in); end
    clr_err = 1; tick(); idle();
  endtask

  task automatic test_random();
    int bad_data;
    for (int n = 0; n < 400; n++) begin
      req_in = ($urandom_range(0, 1) == 1); addr_in = IAW'($urandom);
      out_en = ($urandom_range(0, 1) == 1); addr_out = OAW'($urandom); data_out = $urandom;
      for (int k = 0; k < NI; k++) ext_in_data[k*NB +: NB] = $urandom;
      ext_in_valid = NI'($urandom); ext_out_ready = NO'($urandom & $urandom);
      clr_err = ($urandom_range(0, 15) == 0);
      tick();
      chk++; if (io_in !== io_m) begin err++; $display("FAIL rnd_io_in cyc %0d got %h want %h", n, io_in, io_m); end
      chk++; if (ovf !== ovf_m || udf !== udf_m) begin err++; $display("FAIL rnd_flags cyc %0d got %b/%b want %b/%b", n, ovf, udf, ovf_m, udf_m); end
      bad_data = 0;
      for (int k = 0; k < NO; k++) begin
        if (ext_out_valid[k] !== (out_q[k].size() > 0)) bad_data++;
        else if (out_q[k].size() > 0 && ext_out_data[k*NB +: NB] !== out_q[k][0]) bad_data++;
      end
      for (int k = 0; k < NI; k++)
        if (ext_in_ready[k] !== (in_q[k].size() < FD)) bad_data++;
      chk++; if (bad_data != 0) begin err++; $display("FAIL rnd_channels cyc %0d got %0d bad channels want 0", n, bad_data); end
    end
    idle(); clr_err = 1; tick(); idle();
  endtask

  task automatic test_reset_mid();
    idle(); model_reset(); rst = 1; @(posedge clk); #1; rst = 0;
    ext_in_valid[1] = 1;
    for (int i = 0; i < 4; i++) begin ext_in_data[NB +: NB] = NB'(32'hA0 + i); tick(); end
    idle(); req_in = 1; addr_in = 1; out_en = 1; addr_out = 2; data_out = 32'h5; tick(); idle();
    chk++; if (io_in !== 32'hA0) begin err++; $display("FAIL mid_pre got %h want a0", io_in); end
    #2; rst = 1; #1;
    chk++; if (io_in !== '0 || ext_out_valid !== '0 || ext_in_ready !== '0) begin
      err++; $display("FAIL mid_async got io %h v %b r %b want 0 0 0", io_in, ext_out_valid, ext_in_ready);
    end
    model_reset();
    @(posedge clk); #1; rst = 0;
    req_in = 1; addr_in = 1; tick(); idle();
    chk++; if (udf !== 8'b0000_0010 || io_in !== '0) begin err++; $display("FAIL mid_after got udf %b io %h want 00000010 0", udf, io_in); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_overflow();
    test_underflow();
    test_concurrency();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
